// File: rtl/program_loader_if.sv
// Byte stream in from the UART receiver, word write port out to program memory.
// The loader takes the master side; the memory/receiver pair the slave side.
interface program_loader_if #(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_LENGTH = 16
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [ADDR_LENGTH-1:0] addr_out;
  logic [DATA_LENGTH-1:0] data_out;
  logic                   wr;

  modport master (
    input  rx_data,
    input  rx_valid,
    output addr_out,
    output data_out,
    output wr
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  addr_out,
    input  data_out,
    input  wr
  );
endinterface

// File: rtl/program_loader.sv
// Framed program upload: start byte, 16-bit word count, then big-endian words.
// Writes each word into program memory and holds the BIP off while busy.
module program_loader #(
  parameter int         ADDR_LENGTH = 11,
  parameter int         DATA_LENGTH = 16,
  parameter logic [7:0] START_BYTE  = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  program_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_LENGTH;

  state_t                 state_q, state_d;
  logic [7:0]             byte_hi;
  logic [ADDR_LENGTH:0]   remaining;
  logic [15:0]            count;
  logic [DATA_LENGTH-1:0] word;
  logic                   count_bad;
  logic                   last_word;
  logic                   start, latch_hi;
  logic                   len_ok, len_bad, word_wr;

  assign count     = {byte_hi, bus.rx_data};
  assign word      = {byte_hi, bus.rx_data};
  assign count_bad = (count == 16'd0) || ({1'b0, count} > MAX_WORDS);
  assign last_word = remaining == (ADDR_LENGTH+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE, DONE:
          if (bus.rx_data == START_BYTE) state_d = LEN_HI;
        LEN_HI:  state_d = LEN_LO;
        LEN_LO:  state_d = count_bad ? IDLE : DATA_HI;
        DATA_HI: state_d = DATA_LO;
        DATA_LO: state_d = last_word ? DONE : DATA_HI;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start    = 1'b0;
    latch_hi = 1'b0;
    len_ok   = 1'b0;
    len_bad  = 1'b0;
    word_wr  = 1'b0;
    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE, DONE:
          start = bus.rx_data == START_BYTE;
        LEN_HI, DATA_HI:
          latch_hi = 1'b1;
        LEN_LO: begin
          len_ok  = !count_bad;
          len_bad = count_bad;
        end
        DATA_LO: word_wr = 1'b1;
        default: ;
      endcase
    end
  end

  // Address steps the cycle after a strobe unless that strobe finished the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.addr_out <= '0;
      bus.data_out <= '0;
      bus.wr       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      byte_hi      <= '0;
      remaining    <= '0;
    end else begin
      bus.wr <= word_wr;
      if (bus.wr && state_q != DONE)
        bus.addr_out <= bus.addr_out + 1'b1;
      if (latch_hi)
        byte_hi <= bus.rx_data;
      if (start) begin
        busy         <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        bus.addr_out <= '0;
      end
      if (len_bad) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
      if (len_ok)
        remaining <= count[ADDR_LENGTH:0];
      if (word_wr) begin
        bus.data_out <= word;
        remaining    <= remaining - 1'b1;
        if (last_word) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random framed uploads against a frame-level model.
// Expected writes are word i at address i, one cycle after each low byte.
module tb_program_loader;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, error;

  program_loader_if #(.ADDR_LENGTH(AW), .DATA_LENGTH(16)) bus ();

  program_loader #(
    .ADDR_LENGTH(AW),
    .DATA_LENGTH(16),
    .START_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wide = 0;
  logic wr_prev = 1'b0;

  logic [AW-1:0] got_addr[$], exp_addr[$];
  logic [15:0]   got_data[$], exp_data[$];
  int            got_cyc[$], exp_cyc[$];
  logic [15:0]   words[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.wr) begin
      got_addr.push_back(bus.addr_out);
      got_data.push_back(bus.data_out);
      got_cyc.push_back(cyc);
      if (wr_prev) wide++;
    end
    wr_prev = rst_n && bus.wr;
  end

  task automatic clear_q();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    wide = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int c);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Model: a valid count means word i lands at address i, one cycle after its low byte.
  task automatic send_frame(input logic [15:0] cnt, input int nsend, input int maxgap);
    int c;
    bit ok;
    ok = (cnt != 16'd0) && (int'(cnt) <= (1 << AW));
    send_byte(8'hA5, $urandom_range(maxgap, 0), c);
    send_byte(cnt[15:8], $urandom_range(maxgap, 0), c);
    send_byte(cnt[7:0], $urandom_range(maxgap, 0), c);
    for (int i = 0; i < nsend; i++) begin
      send_byte(words[i][15:8], $urandom_range(maxgap, 0), c);
      send_byte(words[i][7:0], $urandom_range(maxgap, 0), c);
      if (ok) begin
        exp_addr.push_back(AW'(i));
        exp_data.push_back(words[i]);
        exp_cyc.push_back(c);
      end
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    int c;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, bus.wr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000", {busy, done, error, bus.wr});
    end
    checks++;
    if (bus.addr_out !== '0 || bus.data_out !== '0) begin
      failures++;
      $display("FAIL reset_bus: got addr %h data %h required 0/0", bus.addr_out, bus.data_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_byte(8'h11, 3, c);
    checks++;
    if ({busy, done, error} !== 3'b000 || bus.addr_out !== '0 || got_addr.size() != 0) begin
      failures++;
      $display("FAIL reset_ignore: got flags %b addr %h writes %0d required 000/0/0",
               {busy, done, error}, bus.addr_out, got_addr.size());
    end
  endtask

  task automatic test_basic(input int maxgap, input string name);
    int bad = 0;
    clear_q();
    words = '{16'h1234, 16'hABCD};
    send_frame(16'd2, 2, maxgap);
    if (got_addr.size() != exp_addr.size()) bad = 1;
    else foreach (exp_addr[i])
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
        bad++;
    checks++;
    if (bad != 0 || wide != 0) begin
      failures++;
      $display("FAIL %s_writes: got %0d writes (%0d bad, %0d wide) required %0d exact",
               name, got_addr.size(), bad, wide, exp_addr.size());
    end
    checks++;
    if ({busy, done, error} !== 3'b010) begin
      failures++;
      $display("FAIL %s_flags: got busy/done/error %b required 010", name, {busy, done, error});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.addr_out !== AW'(1)) begin
      failures++;
      $display("FAIL %s_addr_hold: got %h required 001", name, bus.addr_out);
    end
  endtask

  task automatic test_bad_counts();
    int c;
    logic [15:0] bads[2];
    bads[0] = 16'h0000;
    bads[1] = 16'h0801;
    foreach (bads[k]) begin
      clear_q();
      send_frame(bads[k], 0, 2);
      checks++;
      if ({busy, done, error} !== 3'b001 || got_addr.size() != 0) begin
        failures++;
        $display("FAIL bad_count_%h: got flags %b writes %0d required 001/0",
                 bads[k], {busy, done, error}, got_addr.size());
      end
    end
    send_byte(8'hA5, 0, c);
    checks++;
    if ({busy, done, error} !== 3'b100) begin
      failures++;
      $display("FAIL restart_clears_error: got %b required 100", {busy, done, error});
    end
    send_byte(8'h00, 0, c);
    send_byte(8'h01, 0, c);
    send_byte(8'hA5, 0, c);
    send_byte(8'hA5, 2, c);
    checks++;
    if ({busy, done, error} !== 3'b010 || got_data.size() != 1 || got_data[0] !== 16'hA5A5) begin
      failures++;
      $display("FAIL start_as_data: got flags %b writes %0d required 010 and one A5A5",
               {busy, done, error}, got_data.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] cnt;
    for (int f = 0; f < 6; f++) begin
      int bad = 0;
      clear_q();
      cnt = (f == 5) ? 16'h00A5 : 16'($urandom_range(8, 1));
      words.delete();
      for (int i = 0; i < int'(cnt); i++) words.push_back(16'($urandom));
      if (f == 2) words[0] = 16'hA5A5;
      send_frame(cnt, int'(cnt), f % 3);
      if (got_addr.size() != exp_addr.size()) bad = 1;
      else foreach (exp_addr[i])
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
          bad++;
      checks++;
      if (bad != 0 || wide != 0 || {busy, done, error} !== 3'b010) begin
        failures++;
        $display("FAIL random_frame%0d: got %0d writes (%0d bad, %0d wide) flags %b required %0d writes flags 010",
                 f, got_addr.size(), bad, wide, {busy, done, error}, exp_addr.size());
      end
    end
  endtask

  task automatic test_mid_reset();
    int c;
    int bad = 0;
    clear_q();
    words = '{16'h1234};
    send_frame(16'd3, 1, 1);
    send_byte(8'h56, 1, c);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== '0 || got_data[0] !== 16'h1234) begin
      failures++;
      $display("FAIL midreset_partial: got %0d writes required one 1234@0", got_addr.size());
    end
    checks++;
    if ({busy, done, error, bus.wr} !== 4'b0000 || bus.addr_out !== '0 || bus.data_out !== '0) begin
      failures++;
      $display("FAIL midreset_clear: got flags %b addr %h data %h required all 0",
               {busy, done, error, bus.wr}, bus.addr_out, bus.data_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    words = '{16'($urandom), 16'($urandom)};
    send_frame(16'd2, 2, 1);
    if (got_addr.size() != exp_addr.size()) bad = 1;
    else foreach (exp_addr[i])
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
        bad++;
    checks++;
    if (bad != 0 || done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reload: got %0d writes (%0d bad) done %b required %0d writes done 1",
               got_addr.size(), bad, done, exp_addr.size());
    end
  endtask

  task automatic test_full();
    int bad = 0;
    int zero_hits = 0;
    clear_q();
    words.delete();
    for (int i = 0; i < (1 << AW); i++) words.push_back(16'(i));
    send_frame(16'h0800, 1 << AW, 0);
    if (got_addr.size() != exp_addr.size()) bad = 1;
    else foreach (exp_addr[i])
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
        bad++;
    foreach (got_addr[i]) if (got_addr[i] == '0) zero_hits++;
    checks++;
    if (bad != 0 || wide != 0) begin
      failures++;
      $display("FAIL full_writes: got %0d writes (%0d bad, %0d wide) required 2048 exact",
               got_addr.size(), bad, wide);
    end
    checks++;
    if (got_addr.size() == 0 || got_addr[$] !== 11'h7FF || got_data[$] !== 16'h07FF) begin
      failures++;
      $display("FAIL full_last: got %0d writes, last addr/data not 7FF/07FF", got_addr.size());
    end
    checks++;
    if (zero_hits != 1 || {busy, done, error} !== 3'b010) begin
      failures++;
      $display("FAIL full_nowrap: got %0d writes at 0, flags %b required 1 and 010",
               zero_hits, {busy, done, error});
    end
  endtask

  initial begin
    test_reset();
    test_basic(3, "basic");
    test_basic(0, "back_to_back");
    test_bad_counts();
    test_random();
    test_mid_reset();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
